// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: tracks in-flight records from EX to WB and drives the ID stall, the EX forward selects and the ID/EX bubble.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/flush event counters.
module pipe_hazard_unit #(
  parameter int NSTAGE     = 3,
  parameter int NRD        = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = 1,
  parameter int SELW       = $clog2(NSTAGE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hold_i,
  input  logic                  issue_valid_i,
  input  logic [REG_AW-1:0]     issue_rd_i,
  input  logic                  issue_regwrite_i,
  input  logic                  issue_load_i,
  input  logic [NRD*REG_AW-1:0] rs_addr_i,
  input  logic [NRD-1:0]        rs_used_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic [NRD*SELW-1:0]   fwd_sel_o,
  output logic [NSTAGE-1:0]     stage_valid_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  logic [NSTAGE-1:0]     valid_q, valid_d, regwrite_q, regwrite_d, load_q, load_d;
  logic [REG_AW-1:0]     rd_q [NSTAGE];
  logic [REG_AW-1:0]     rd_d [NSTAGE];
  // Only the EX record is ever asked for its sources, so later stages do not keep them.
  logic [NRD*REG_AW-1:0] rs0_q, rs0_d;
  logic [NRD-1:0]        used0_q, used0_d;
  logic                  stall_raw, bubble_raw;

  generate
    if (LOAD_STAGE == 0) begin : g_no_stall
      assign stall_raw = 1'b0;
    end else begin : g_stall
      logic [NRD-1:0] port_hit;
      for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        logic [REG_AW-1:0]     src;
        logic [LOAD_STAGE-1:0] stage_hit;
        assign src = rs_addr_i[gi*REG_AW +: REG_AW];
        for (genvar gk = 0; gk < LOAD_STAGE; gk++) begin : g_stage
          assign stage_hit[gk] = valid_q[gk] & regwrite_q[gk] & load_q[gk] &
                                 (rd_q[gk] == src) & (src != '0);
        end
        assign port_hit[gi] = rs_used_i[gi] & (|stage_hit);
      end
      assign stall_raw = issue_valid_i & ~flush_i & (|port_hit);
    end
  endgenerate

  assign bubble_raw    = stall_raw | flush_i | ~issue_valid_i;
  assign stall_o       = stall_raw;
  assign bubble_o      = ~rst_i & bubble_raw;
  assign stage_valid_o = valid_q;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_fwd
      logic [REG_AW-1:0] src;
      logic [SELW-1:0]   sel;
      assign src = rs0_q[gi*REG_AW +: REG_AW];
      // Walk oldest to youngest so the youngest producer overwrites.
      always_comb begin
        sel = '0;
        for (int k = NSTAGE - 1; k >= 1; k--) begin
          if (used0_q[gi] && valid_q[k] && regwrite_q[k] && (rd_q[k] == src) && (src != '0)) begin
            sel = SELW'(k);
          end
        end
      end
      assign fwd_sel_o[gi*SELW +: SELW] = sel;
    end
  endgenerate

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    load_d     = load_q;
    rd_d       = rd_q;
    rs0_d      = rs0_q;
    used0_d    = used0_q;
    if (!hold_i) begin
      for (int k = NSTAGE - 1; k > 0; k--) begin
        valid_d[k]    = valid_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
        load_d[k]     = load_q[k-1];
        rd_d[k]       = rd_q[k-1];
      end
      valid_d[0]    = ~bubble_raw;
      regwrite_d[0] = ~bubble_raw & issue_regwrite_i;
      load_d[0]     = ~bubble_raw & issue_load_i;
      rd_d[0]       = bubble_raw ? '0 : issue_rd_i;
      rs0_d         = bubble_raw ? '0 : rs_addr_i;
      used0_d       = bubble_raw ? '0 : rs_used_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      load_q     <= '0;
      rs0_q      <= '0;
      used0_q    <= '0;
      for (int k = 0; k < NSTAGE; k++) rd_q[k] <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      rs0_q      <= rs0_d;
      used0_q    <= used0_d;
    end
  end

  // A load still inside stages 0..LOAD_STAGE has no data to forward; stall_o must have prevented this.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NRD; r++) begin
        for (int k = 1; k < NSTAGE; k++) begin
          if (k <= LOAD_STAGE) begin
            assert (!((fwd_sel_o[r*SELW +: SELW] == SELW'(k)) && load_q[k]));
          end
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold_i) begin
      if (stall_raw && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Replaces fixed two-source forwarding and single-stage load-use detection with a depth- and port-generic tracker.
- Holds a shadow record of every in-flight instruction from EX to WB.
- Generates the ID-stage stall, the EX-stage operand forward selects, and the bubble/flush control for the ID/EX boundary.

Parameters:
NSTAGE, 3, tracked stages after ID (stage 0 = EX, NSTAGE-1 = WB); legal range 2..8
NRD, 2, source-operand read ports per instruction; legal range 1..4
REG_AW, 5, register address width
LOAD_STAGE, 1, stage index whose end produces load data; legal range 0..NSTAGE-2
SELW, $clog2(NSTAGE), forward-select width per port

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
hold_i  in  1  global freeze (e.g. memory wait); all stage records hold
issue_valid_i  in  1  ID holds a real instruction
issue_rd_i  in  REG_AW  ID destination register
issue_regwrite_i  in  1  ID instruction writes rd
issue_load_i  in  1  ID instruction is a load
rs_addr_i  in  NRD*REG_AW  ID source addresses, port r at [r*REG_AW +: REG_AW]
rs_used_i  in  NRD  ID port r is read
flush_i  in  1  taken branch; kill the ID instruction
stall_o  out  1  hold PC and IF/ID; insert bubble into EX
bubble_o  out  1  stage 0 loads an empty record this edge
fwd_sel_o  out  NRD*SELW  per EX port: 0 = register file, k = result of stage k
stage_valid_o  out  NSTAGE  valid bit of each stage record

Behaviour:
- Reset (async, rst_i=1): all records cleared (valid, regwrite, load, rd, rs, used = 0).
  - Outputs during reset: stall_o=0, bubble_o=0, fwd_sel_o=0, stage_valid_o=0.
  - Reset deassertion mid-stream discards all in-flight records. No recovery.
- Stage record fields: valid, rd, regwrite, load, rs[NRD], used[NRD].
- Matching rule:
  - match(k, a) = valid[k] & regwrite[k] & (rd[k]==a) & (a!=0).
  - x0 never matches.
- stall_o is combinational:
  - Equals issue_valid_i & ~flush_i & OR over r with used[r], and k in 0..LOAD_STAGE-1, of (match(k, rs_addr_i[r]) & load[k]).
  - LOAD_STAGE=0: stall_o is constant 0.
- bubble_o = stall_o | flush_i | ~issue_valid_i.
- Clock edge with hold_i=1: no record changes. stall_o is still computed.
- Clock edge with hold_i=0:
  - Records shift: record k+1 takes record k.
  - Record NSTAGE-1 retires.
  - Record 0 takes the ID fields when bubble_o=0. Otherwise record 0 takes all zeros.
- flush_i with stall_o condition true in the same cycle: flush wins. stall_o=0, bubble inserted, ID instruction dropped.
- fwd_sel_o[r] depends on registered state only (glitch-free relative to ID inputs):
  - If used[0][r]=0, the select is 0.
  - Otherwise the select is the smallest k in 1..NSTAGE-1 with match(k, rs[0][r]); 0 if none.
  - Youngest producer has priority.
- Forwarding from a load record at k ≤ LOAD_STAGE is architecturally impossible given stall_o.
  - A simulation-only assertion flags it.
- Records and all control are fully synchronous apart from reset. No combinational path from hold_i to fwd_sel_o.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN
- Defined:
  - Adds outputs stall_cnt_o (32) and flush_cnt_o (32).
  - Counters are saturating at 32'hFFFF_FFFF and reset to 0.
  - Counting happens on clock edges with hold_i=0: stall_cnt_o on stall_o=1, flush_cnt_o on flush_i=1.
- Undefined: ports and counters absent. All other behaviour identical.

Test Plan (NSTAGE=3, NRD=2, LOAD_STAGE=1 unless stated):
- Reset mid-stream, with 3 valid records in flight: assert rst_i between edges -> stage_valid_o=3'b000, fwd_sel_o=0 and stall_o=0 immediately, no clock needed.
- ALU chain:
  - Issue add x5. Next cycle, issue instruction with rs1=x5 -> when it reaches EX, fwd_sel port0=1.
  - Instruction with rs2=x5 two cycles after the add -> port1=2.
  - Instruction with rs1=x5 three cycles after the add -> port0=0.
- Load-use:
  - Issue lw x6. Next ID instruction has rs2=x6 -> stall_o=1 for exactly one cycle, bubble_o=1, stage_valid_o=3'b011.
  - Then the dependent instruction enters EX with fwd_sel port1=2.
- x0 and priority:
  - Writes to x7 in stages 1 and 2, EX reads x7 -> sel=1.
  - Same sequence with x0 -> sel=0.
  - lw x0 followed by a use of x0 -> no stall.
- Flush+stall and hold:
  - flush_i=1 in the load-use cycle -> stall_o=0, bubble in stage 0, flush_cnt_o +1 (PERF_EN).
  - hold_i=1 for 4 cycles -> stage_valid_o and fwd_sel_o unchanged, counters unchanged.
- Generic depth (NSTAGE=5, LOAD_STAGE=2):
  - lw x9, then use of x9 -> stall_o=1 for 2 cycles.
  - Then fwd_sel=3.
